// File: rtl/rv32_exec_unit.sv
// Registered RV32I execute stage: operand select, ALU with shared adder, branch compare, next PC.
// Define EXEC_TRACE_EN to print one trace line per accepted instruction in simulation.
module rv32_exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            rst,
    input  logic            i_vld,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    input  logic [3:0]      i_alu_op,
    input  logic            i_opa_sel,
    input  logic [1:0]      i_opb_sel,
    input  logic            i_br_un,
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_funct3,
    output logic            o_vld,
    output logic [XLEN-1:0] o_alu_y,
    output logic            o_zero,
    output logic            o_cout,
    output logic            o_ovf,
    output logic            o_br_equal,
    output logic            o_br_less,
    output logic            o_take_branch,
    output logic [XLEN-1:0] o_pc_next
);

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    logic [XLEN-1:0] op_a, op_b, b_add;
    logic            sub;
    logic [XLEN:0]   sum;
    logic            add_ovf;
    logic [4:0]      shamt;
    logic            br_equal, br_less, take_branch;
    logic [XLEN-1:0] br_target, jalr_target, pc_next;

    logic            vld_q, zero_q, cout_q, ovf_q, br_equal_q, br_less_q, take_q;
    logic [XLEN-1:0] alu_y_q, pc_next_q;
    logic            zero_d, cout_d, ovf_d;
    logic [XLEN-1:0] alu_y_d;

    always_comb begin
        op_a = i_opa_sel ? i_pc : i_rs1;
        unique case (i_opb_sel)
            2'b00:   op_b = i_rs2;
            2'b01:   op_b = i_imm;
            default: op_b = XLEN'(4);
        endcase
    end

    // One adder serves ADD, SUB and both set-less-than ops; the compares are subtractions.
    assign sub     = (i_alu_op == AluSub) || (i_alu_op == AluSlt) || (i_alu_op == AluSltu);
    assign b_add   = sub ? ~op_b : op_b;
    assign sum     = {1'b0, op_a} + {1'b0, b_add} + {{XLEN{1'b0}}, sub};
    assign add_ovf = (op_a[XLEN-1] == b_add[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
    assign shamt   = op_b[4:0];

    always_comb begin
        alu_y_d = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        case (i_alu_op)
            AluAdd, AluSub: begin
                alu_y_d = sum[XLEN-1:0];
                cout_d  = sum[XLEN];
                ovf_d   = add_ovf;
            end
            AluSll:   alu_y_d = op_a << shamt;
            AluSlt:   alu_y_d = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ add_ovf};
            AluSltu:  alu_y_d = {{(XLEN-1){1'b0}}, ~sum[XLEN]};
            AluXor:   alu_y_d = op_a ^ op_b;
            AluSrl:   alu_y_d = op_a >> shamt;
            AluSra:   alu_y_d = $unsigned($signed(op_a) >>> shamt);
            AluOr:    alu_y_d = op_a | op_b;
            AluAnd:   alu_y_d = op_a & op_b;
            AluPassB: alu_y_d = op_b;
            default:  alu_y_d = '0;
        endcase
        zero_d = (alu_y_d == '0);
    end

    // Branch comparator always looks at the raw register operands.
    assign br_equal = (i_rs1 == i_rs2);
    assign br_less  = i_br_un ? (i_rs1 < i_rs2) : ($signed(i_rs1) < $signed(i_rs2));

    always_comb begin
        take_branch = 1'b0;
        unique case (i_funct3)
            3'b000:         take_branch = br_equal;
            3'b001:         take_branch = ~br_equal;
            3'b100, 3'b110: take_branch = br_less;
            3'b101, 3'b111: take_branch = ~br_less;
            default:        take_branch = 1'b0;
        endcase
        take_branch = take_branch & i_is_branch;
    end

    assign br_target   = i_pc + i_imm;
    assign jalr_target = (i_rs1 + i_imm) & ~XLEN'(1);

    always_comb begin
        pc_next = i_pc + XLEN'(4);
        if (i_is_jalr) begin
            pc_next = jalr_target;
        end else if (i_is_jal || take_branch) begin
            pc_next = br_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            vld_q      <= 1'b0;
            alu_y_q    <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            br_equal_q <= 1'b0;
            br_less_q  <= 1'b0;
            take_q     <= 1'b0;
            pc_next_q  <= '0;
        end else begin
            vld_q <= i_vld;
            if (i_vld) begin
                alu_y_q    <= alu_y_d;
                zero_q     <= zero_d;
                cout_q     <= cout_d;
                ovf_q      <= ovf_d;
                br_equal_q <= br_equal;
                br_less_q  <= br_less;
                take_q     <= take_branch;
                pc_next_q  <= pc_next;
            end
        end
    end

`ifdef EXEC_TRACE_EN
    always @(posedge i_clk) begin
        if (rst && i_vld) begin
            $display("EX PC=%08x Y=%08x NPC=%08x BR=%0d", i_pc, alu_y_d, pc_next, take_branch);
        end
    end
`else
`endif

    assign o_vld         = vld_q;
    assign o_alu_y       = alu_y_q;
    assign o_zero        = zero_q;
    assign o_cout        = cout_q;
    assign o_ovf         = ovf_q;
    assign o_br_equal    = br_equal_q;
    assign o_br_less     = br_less_q;
    assign o_take_branch = take_q;
    assign o_pc_next     = pc_next_q;

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Directed, table-driven bench for rv32_exec_unit with hand-computed expected values.
module tb_rv32_exec_unit;

    logic        i_clk = 1'b0;
    logic        rst;
    logic        i_vld;
    logic [31:0] i_pc, i_rs1, i_rs2, i_imm;
    logic [3:0]  i_alu_op;
    logic        i_opa_sel;
    logic [1:0]  i_opb_sel;
    logic        i_br_un, i_is_branch, i_is_jal, i_is_jalr;
    logic [2:0]  i_funct3;
    logic        o_vld, o_zero, o_cout, o_ovf, o_br_equal, o_br_less, o_take_branch;
    logic [31:0] o_alu_y, o_pc_next;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    rv32_exec_unit dut (
        .i_clk        (i_clk),
        .rst          (rst),
        .i_vld        (i_vld),
        .i_pc         (i_pc),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .i_imm        (i_imm),
        .i_alu_op     (i_alu_op),
        .i_opa_sel    (i_opa_sel),
        .i_opb_sel    (i_opb_sel),
        .i_br_un      (i_br_un),
        .i_is_branch  (i_is_branch),
        .i_is_jal     (i_is_jal),
        .i_is_jalr    (i_is_jalr),
        .i_funct3     (i_funct3),
        .o_vld        (o_vld),
        .o_alu_y      (o_alu_y),
        .o_zero       (o_zero),
        .o_cout       (o_cout),
        .o_ovf        (o_ovf),
        .o_br_equal   (o_br_equal),
        .o_br_less    (o_br_less),
        .o_take_branch(o_take_branch),
        .o_pc_next    (o_pc_next)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        opa;
        logic [1:0]  opb;
        logic [31:0] pc, rs1, rs2, imm;
        logic        brun, isbr, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] y;
        logic        z, c, v, eq, lt, tk;
        logic [31:0] npc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [3:0] op, logic opa, logic [1:0] opb,
                                logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic brun, logic isbr, logic jal,
                                logic jalr, logic [2:0] f3, logic [31:0] y, logic z,
                                logic c, logic v, logic eq, logic lt, logic tk,
                                logic [31:0] npc);
        vec_t t;
        t.name = name; t.op = op; t.opa = opa; t.opb = opb; t.pc = pc; t.rs1 = rs1;
        t.rs2 = rs2; t.imm = imm; t.brun = brun; t.isbr = isbr; t.jal = jal; t.jalr = jalr;
        t.f3 = f3; t.y = y; t.z = z; t.c = c; t.v = v; t.eq = eq; t.lt = lt; t.tk = tk;
        t.npc = npc;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08x expected %08x", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t, logic vld);
        i_vld = vld; i_alu_op = t.op; i_opa_sel = t.opa; i_opb_sel = t.opb;
        i_pc = t.pc; i_rs1 = t.rs1; i_rs2 = t.rs2; i_imm = t.imm; i_br_un = t.brun;
        i_is_branch = t.isbr; i_is_jal = t.jal; i_is_jalr = t.jalr; i_funct3 = t.f3;
    endtask

    task automatic check_outs(string tag, logic vld, vec_t t);
        check({tag, ".vld"},  {31'd0, o_vld}, {31'd0, vld});
        check({tag, ".y"},    o_alu_y, t.y);
        check({tag, ".zero"}, {31'd0, o_zero}, {31'd0, t.z});
        check({tag, ".cout"}, {31'd0, o_cout}, {31'd0, t.c});
        check({tag, ".ovf"},  {31'd0, o_ovf}, {31'd0, t.v});
        check({tag, ".eq"},   {31'd0, o_br_equal}, {31'd0, t.eq});
        check({tag, ".lt"},   {31'd0, o_br_less}, {31'd0, t.lt});
        check({tag, ".take"}, {31'd0, o_take_branch}, {31'd0, t.tk});
        check({tag, ".npc"},  o_pc_next, t.npc);
    endtask

    vec_t zero_v, junk_v, last_v;

    initial begin
        //              name     op  a  b   pc           rs1          rs2          imm
        //              un br jal jalr f3  y            z  c  v  eq lt tk npc
        vecs.push_back(mk("add5_7", 0, 0, 0, 32'h100, 32'd5, 32'd7, 32'd0,
                          0, 0, 0, 0, 0, 32'd12, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("add_ovf", 0, 0, 0, 32'h100, 32'h7FFFFFFF, 32'd1, 32'd0,
                          0, 0, 0, 0, 0, 32'h80000000, 0, 0, 1, 0, 0, 0, 32'h104));
        vecs.push_back(mk("add_cout", 0, 0, 0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd0,
                          0, 0, 0, 0, 0, 32'd0, 1, 1, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("sub3_3", 1, 0, 0, 32'h100, 32'd3, 32'd3, 32'd0,
                          0, 0, 0, 0, 0, 32'd0, 1, 1, 0, 1, 0, 0, 32'h104));
        vecs.push_back(mk("sub_ovf", 1, 0, 0, 32'h100, 32'h80000000, 32'd1, 32'd0,
                          0, 0, 0, 0, 0, 32'h7FFFFFFF, 0, 1, 1, 0, 1, 0, 32'h104));
        vecs.push_back(mk("sub_borrow", 1, 0, 0, 32'h100, 32'd0, 32'd1, 32'd0,
                          0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("sra", 7, 0, 1, 32'h100, 32'h80000000, 32'd0, 32'h21,
                          0, 0, 0, 0, 0, 32'hC0000000, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("slt", 3, 0, 0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd0,
                          0, 0, 0, 0, 0, 32'd1, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("sltu", 4, 0, 0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd0,
                          1, 0, 0, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0, 32'h104));
        vecs.push_back(mk("passb", 10, 0, 1, 32'h100, 32'd0, 32'd0, 32'h12345000,
                          0, 0, 0, 0, 0, 32'h12345000, 0, 0, 0, 1, 0, 0, 32'h104));
        vecs.push_back(mk("xor", 5, 0, 0, 32'h100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,
                          0, 0, 0, 0, 0, 32'hFF00FF00, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("sll", 2, 0, 0, 32'h100, 32'd1, 32'h23, 32'd0,
                          0, 0, 0, 0, 0, 32'd8, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("srl", 6, 0, 0, 32'h100, 32'h80000000, 32'd4, 32'd0,
                          0, 0, 0, 0, 0, 32'h08000000, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk("or", 8, 0, 0, 32'h100, 32'hF0, 32'h0F, 32'd0,
                          0, 0, 0, 0, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 32'h104));
        vecs.push_back(mk("and", 9, 0, 0, 32'h100, 32'hF0, 32'h0F, 32'd0,
                          0, 0, 0, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0, 32'h104));
        vecs.push_back(mk("op12", 12, 0, 0, 32'h100, 32'd5, 32'd5, 32'd0,
                          0, 0, 0, 0, 0, 32'd0, 1, 0, 0, 1, 0, 0, 32'h104));
        vecs.push_back(mk("beq", 0, 1, 1, 32'h100, 32'd9, 32'd9, 32'h20,
                          0, 1, 0, 0, 3'b000, 32'h120, 0, 0, 0, 1, 0, 1, 32'h120));
        vecs.push_back(mk("blt", 0, 1, 1, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20,
                          0, 1, 0, 0, 3'b100, 32'h120, 0, 0, 0, 0, 1, 1, 32'h120));
        vecs.push_back(mk("bltu", 0, 1, 1, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20,
                          1, 1, 0, 0, 3'b110, 32'h120, 0, 0, 0, 0, 0, 0, 32'h104));
        vecs.push_back(mk("bne_eq", 0, 1, 1, 32'h100, 32'd4, 32'd4, 32'h20,
                          0, 1, 0, 0, 3'b001, 32'h120, 0, 0, 0, 1, 0, 0, 32'h104));
        vecs.push_back(mk("bge", 0, 1, 1, 32'h100, 32'd1, 32'hFFFFFFFF, 32'h20,
                          0, 1, 0, 0, 3'b101, 32'h120, 0, 0, 0, 0, 0, 1, 32'h120));
        vecs.push_back(mk("br_f3_010", 0, 1, 1, 32'h100, 32'd0, 32'd0, 32'h20,
                          0, 1, 0, 0, 3'b010, 32'h120, 0, 0, 0, 1, 0, 0, 32'h104));
        vecs.push_back(mk("jal", 0, 1, 2, 32'h100, 32'd0, 32'd0, 32'hFFFFFFF8,
                          0, 0, 1, 0, 0, 32'h104, 0, 0, 0, 1, 0, 0, 32'hF8));
        vecs.push_back(mk("jalr", 0, 1, 2, 32'h100, 32'h203, 32'd0, 32'd0,
                          0, 0, 0, 1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 32'h202));
        vecs.push_back(mk("jal_jalr", 0, 0, 1, 32'h100, 32'h300, 32'd0, 32'h11,
                          0, 0, 1, 1, 0, 32'h311, 0, 0, 0, 0, 0, 0, 32'h310));
        vecs.push_back(mk("pc_wrap", 0, 1, 2, 32'hFFFFFFFC, 32'd0, 32'd0, 32'd0,
                          0, 0, 0, 0, 0, 32'd0, 1, 1, 0, 1, 0, 0, 32'd0));

        zero_v = mk("zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        junk_v = mk("junk", 1, 1, 1, 32'h1234, 32'h5, 32'h5, 32'h40, 1, 1, 1, 1, 3'b000,
                    0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with busy, valid-looking inputs: everything must stay cleared.
        rst = 1'b0;
        drive(junk_v, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk); #1;
            check_outs($sformatf("reset%0d", i), 1'b0, zero_v);
        end
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i], 1'b1);
            @(posedge i_clk); #1;
            check_outs(vecs[i].name, 1'b1, vecs[i]);
        end
        last_v = vecs[vecs.size()-1];

        // Bubble: o_vld drops, everything else holds the last result.
        drive(junk_v, 1'b0);
        @(posedge i_clk); #1;
        check_outs("hold1", 1'b0, last_v);
        @(posedge i_clk); #1;
        check_outs("hold2", 1'b0, last_v);

        // Reissue a jump after the bubble, then reset mid-stream.
        drive(vecs[22], 1'b1);
        @(posedge i_clk); #1;
        check_outs("after_hold", 1'b1, vecs[22]);
        rst = 1'b0;
        @(posedge i_clk); #1;
        check_outs("mid_reset", 1'b0, zero_v);
        rst = 1'b1;
        drive(vecs[0], 1'b1);
        @(posedge i_clk); #1;
        check_outs("post_reset", 1'b1, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_exec_unit.md
Name: rv32_exec_unit

Overview:
- Registered execute stage for the single-cycle RV32I core; one instruction per cycle, one-cycle latency.
- Selects operands, computes the ALU result with an internal 32-bit ripple/carry adder, and compares rs1/rs2 for branches.
- Computes the next PC (PC+4, branch/JAL target, or JALR target).
- Sits between decode (regfile/immgen/control) and LSU/writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_vld  in  1  input operands/controls valid this cycle.
- i_pc  in  32  PC of the instruction.
- i_rs1  in  32  rs1 data.
- i_rs2  in  32  rs2 data.
- i_imm  in  32  sign-extended immediate.
- i_alu_op  in  4  ALU operation, encoding below.
- i_opa_sel  in  1  0: A=rs1; 1: A=pc.
- i_opb_sel  in  2  00: B=rs2; 01: B=imm; 10/11: B=32'd4.
- i_br_un  in  1  1: unsigned branch compare.
- i_is_branch  in  1  conditional branch.
- i_is_jal  in  1  JAL.
- i_is_jalr  in  1  JALR.
- i_funct3  in  3  branch condition.
- o_vld  out  1  registered i_vld.
- o_alu_y  out  32  ALU result.
- o_zero  out  1  o_alu_y==0.
- o_cout  out  1  adder carry-out (ADD/SUB only, else 0).
- o_ovf  out  1  signed overflow (ADD/SUB only, else 0).
- o_br_equal  out  1  rs1==rs2.
- o_br_less  out  1  rs1<rs2, signed or unsigned per i_br_un.
- o_take_branch  out  1  branch condition met.
- o_pc_next  out  32  next PC.

Behaviour:
- All outputs are registered on the rising edge of i_clk. The result for inputs sampled at edge N is visible after edge N.
- Reset: when rst==0 at an edge, all outputs clear to 0, including o_pc_next=0. Reset takes priority over i_vld.
- When i_vld==0 at an edge, o_vld<=0 and all other outputs hold their previous values.
- ALU op encoding:
  - 0 ADD: A+B.
  - 1 SUB: A+~B+1.
  - 2 SLL: A<<B[4:0].
  - 3 SLT: signed.
  - 4 SLTU: unsigned.
  - 5 XOR.
  - 6 SRL.
  - 7 SRA: arithmetic shift right.
  - 8 OR.
  - 9 AND.
  - 10 PASSB: y=B, used for LUI.
  - 11-15: y=0.
- SLT/SLTU produce 32'd0 or 32'd1.
- Shifts use only B[4:0].
- Adder: a single 32-bit add with carry-in, shared by ADD/SUB/SLT/SLTU.
  - cout is bit 32 of the sum.
  - ovf = (a[31]==b'[31]) && (sum[31]!=a[31]), where b' is the inverted B for SUB.
  - SUB cout=1 means no borrow.
- Comparator:
  - equal = rs1==rs2.
  - less = signed compare when br_un==0, unsigned when br_un==1.
  - The comparator always uses i_rs1/i_rs2, independent of the operand muxes.
- take_branch = i_is_branch AND condition:
  - funct3 000: equal.
  - 001: !equal.
  - 100 and 110: less.
  - 101 and 111: !less.
  - 010/011: 0.
- Targets:
  - br/jal target = i_pc+i_imm (wrap mod 2^32).
  - jalr target = (i_rs1+i_imm) & ~1.
- Next PC priority, highest first:
  - jalr: jalr target.
  - jal: br/jal target.
  - take_branch: br/jal target.
  - otherwise: i_pc+4, wrapping FFFFFFFC→00000000.
- All arithmetic wraps modulo 2^32; no exceptions, no misalignment trap.

Optional Feature:
- Macro: EXEC_TRACE_EN.
- When defined: at each rising edge with rst==1 and i_vld==1, the block prints the line "EX PC=%08x Y=%08x NPC=%08x BR=%0d", using the values being registered.
- When undefined: no simulation output; logic is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with arbitrary inputs → all outputs 0. Release, apply ADD rs1=5 rs2=7 → next cycle o_alu_y=12, o_zero=0, o_vld=1.
- Adder flags:
  - ADD 0x7FFFFFFF+1 → y=0x80000000, ovf=1, cout=0.
  - ADD 0xFFFFFFFF+1 → y=0, zero=1, cout=1, ovf=0.
  - SUB 3-3 → y=0, cout=1.
- Shifts and compares:
  - SRA 0x80000000 by B=0x21 → 0xC0000000 (shift 1).
  - SLT -1<1 → 1.
  - SLTU 0xFFFFFFFF<1 → 0.
  - PASSB imm=0x12345000 → 0x12345000.
- Branches, pc=0x100, imm=0x20:
  - BEQ rs1=rs2 → pc_next=0x120, take=1.
  - BLT rs1=-1 rs2=1 br_un=0 → 0x120.
  - BLTU same operands, br_un=1 → take=0, pc_next=0x104.
- Jumps:
  - JAL pc=0x100 imm=-8 → 0xF8.
  - JALR rs1=0x203 imm=0 → 0x202.
  - jal and jalr both set → jalr target.
- Hold and wrap:
  - i_vld=0 → o_vld=0, other outputs unchanged.
  - pc=0xFFFFFFFC, no jump/branch → pc_next=0.
